// File: rtl/result_unloader.sv
// Drains the matmul result region from data memory as big-endian words, row-major.
// Define RESULT_UNLOADER_CHECKSUM_EN to append a mod-2^32 sum trailer word.
module result_unloader #(
    parameter int M      = 2,
    parameter int N      = 4,
    parameter int N2     = 2,
    parameter int W      = 32,
    parameter int ADDR_W = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic [7:0]        out_row,
    output logic [7:0]        out_col,
    output logic              out_last,
    output logic              busy,
    output logic              finished
);

    localparam int BASE = M * N * 4 + N * N2 * 4;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        OUT,
        TRL,
        FIN
    } state_t;

    state_t            state_q, state_d;
    logic              start_q;
    logic              rd_q;
    logic [2:0]        cnt_q;
    logic [7:0]        row_q;
    logic [7:0]        col_q;
    logic [W-1:0]      word_q;
    logic [W-1:0]      sum_q;
    logic              trl_q;
    logic              last_word;
    logic [ADDR_W-1:0] rd_addr;

    assign last_word = (row_q == 8'(M - 1)) && (col_q == 8'(N2 - 1));
    assign rd_addr   = ADDR_W'(BASE + 4 * (int'(row_q) * N2 + int'(col_q))
                               + int'(cnt_q));

    always_comb begin
        state_d   = state_q;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        finished  = 1'b0;
        out_data  = word_q;
        out_row   = trl_q ? 8'hFF : row_q;
        out_col   = trl_q ? 8'hFF : col_q;
        unique case (state_q)
            IDLE: begin
                if (start && !start_q)
                    state_d = RD;
            end
            RD: begin
                busy = 1'b1;
                // cnt 4 is the bubble that waits for the last byte to land
                if (cnt_q != 3'd4) begin
                    mem_rd   = 1'b1;
                    mem_addr = rd_addr;
                end else begin
                    state_d = OUT;
                end
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
`ifdef RESULT_UNLOADER_CHECKSUM_EN
                out_last = trl_q;
                if (out_ready) begin
                    if (trl_q)
                        state_d = FIN;
                    else if (last_word)
                        state_d = TRL;
                    else
                        state_d = RD;
                end
`else
                out_last = last_word;
                if (out_ready)
                    state_d = last_word ? FIN : RD;
`endif
            end
            TRL: begin
                busy    = 1'b1;
                state_d = OUT;
            end
            FIN: begin
                finished = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            rd_q    <= 1'b0;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            rd_q    <= mem_rd;
            if (rd_q)
                word_q <= {word_q[W-9:0], mem_rdata};
            if (state_q == TRL)
                word_q <= sum_q;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    row_q <= '0;
                    col_q <= '0;
                end
                RD: cnt_q <= (cnt_q == 3'd4) ? 3'd0 : cnt_q + 3'd1;
                OUT: begin
                    if (out_ready && !trl_q && !last_word) begin
                        if (col_q == 8'(N2 - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + 8'd1;
                        end else begin
                            col_q <= col_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RESULT_UNLOADER_CHECKSUM_EN
    always_ff @(posedge CLOCK_50) begin
        if (reset || state_q == IDLE) begin
            sum_q <= '0;
            trl_q <= 1'b0;
        end else if (state_q == OUT && out_ready && !trl_q) begin
            sum_q <= sum_q + word_q;
        end else if (state_q == TRL) begin
            trl_q <= 1'b1;
        end
    end
`else
    assign sum_q = '0;
    assign trl_q = 1'b0;
`endif

endmodule

// File: tb/tb_result_unloader.sv
// Directed bench for result_unloader: drain, byte order, stall, start filtering, reset.
// Expects a checksum trailer when RESULT_UNLOADER_CHECKSUM_EN is defined.
module tb_result_unloader;

    logic        CLOCK_50;
    logic        reset;
    logic        start;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_row;
    logic [7:0]  out_col;
    logic        out_last;
    logic        busy;
    logic        finished;

    logic [7:0]  mem [256];
    bit          noise;
    int          n_chk;
    int          n_pass;

`ifdef RESULT_UNLOADER_CHECKSUM_EN
    localparam bit DATA_LAST = 1'b0;
`else
    localparam bit DATA_LAST = 1'b1;
`endif

    result_unloader dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .finished  (finished)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50)
        if (mem_rd)
            mem_rdata <= mem[mem_addr[7:0]];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        if (noise)
            start = ~start;
    endtask

    task automatic put_word(input int a, input logic [31:0] v);
        mem[a]     = v[31:24];
        mem[a + 1] = v[23:16];
        mem[a + 2] = v[15:8];
        mem[a + 3] = v[7:0];
    endtask

    task automatic recv(input string tag, input logic [31:0] d,
                        input logic [7:0] r, input logic [7:0] c,
                        input logic l, output int gap);
        gap = 0;
        while (!out_valid && gap < 50) begin
            tick();
            gap++;
        end
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".data"}, out_data, d);
        chk({tag, ".rc"}, {16'd0, out_row, out_col}, {16'd0, r, c});
        chk({tag, ".last"}, 32'(out_last), 32'(l));
        tick();
    endtask

    task automatic drain(input string tag, input logic [31:0] w0,
                         input bit noisy, input int stall);
        logic [31:0] exp_w [4];
        logic [31:0] acc;
        int          gap;
        int          gap0;
        int          bad;
        exp_w = '{w0, 32'd60, 32'd114, 32'd140};
        acc   = '0;
        gap0  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        noise = noisy;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i == stall) begin
                out_ready = 1'b0;
                while (!out_valid && gap0 < 50) begin
                    tick();
                    gap0++;
                end
                put_word(64 + 4 * i, 32'hDEADBEEF);
                bad = 0;
                for (int k = 0; k < 10; k++) begin
                    if (!out_valid || out_data !== exp_w[i] || mem_rd ||
                        out_row !== 8'(i / 2) || out_col !== 8'(i % 2))
                        bad++;
                    tick();
                end
                chk({tag, ".stall"}, 32'(bad), 32'd0);
                put_word(64 + 4 * i, exp_w[i]);
                out_ready = 1'b1;
            end
            recv($sformatf("%s.w%0d", tag, i), exp_w[i], 8'(i / 2),
                 8'(i % 2), DATA_LAST && i == 3, gap);
            if (i == stall)
                gap = gap0;
            chk($sformatf("%s.gap%0d", tag, i), 32'(gap), 32'd5);
            acc = acc + exp_w[i];
        end
`ifdef RESULT_UNLOADER_CHECKSUM_EN
        recv({tag, ".trl"}, acc, 8'hFF, 8'hFF, 1'b1, gap);
        chk({tag, ".trlgap"}, 32'(gap), 32'd1);
`endif
        noise = 1'b0;
        if (noisy)
            start = 1'b1;
        chk({tag, ".fin"}, 32'(finished), 32'd1);
        tick();
        chk({tag, ".fin_end"}, {30'd0, finished, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gap;
        int cnt;
        n_chk     = 0;
        n_pass    = 0;
        noise     = 1'b0;
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        for (int a = 0; a < 256; a++)
            mem[a] = 8'h00;
        for (int w = 0; w < 8; w++) begin
            put_word(4 * w, 32'(w + 1));
            put_word(32 + 4 * w, 32'(w + 1));
        end
        put_word(64, 32'd50);
        put_word(68, 32'd60);
        put_word(72, 32'd114);
        put_word(76, 32'd140);

        repeat (3) tick();
        chk("rst.ctl", {11'd0, out_valid, busy, mem_rd, finished, out_last,
                        mem_addr}, 32'd0);
        chk("rst.data", out_data, 32'd0);
        chk("rst.idx", {16'd0, out_row, out_col}, 32'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("idle.busy", 32'(busy), 32'd0);

        drain("basic", 32'd50, 1'b0, -1);

        put_word(64, 32'hFFFFFFF9);
        drain("sign", 32'hFFFFFFF9, 1'b0, -1);
        put_word(64, 32'd50);

        drain("bp", 32'd50, 1'b0, 1);

        drain("noisy", 32'd50, 1'b1, -1);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (busy || out_valid || mem_rd)
                cnt++;
            tick();
        end
        chk("level.norestart", 32'(cnt), 32'd0);
        start = 1'b0;
        tick();
        drain("rearm", 32'd50, 1'b0, -1);

        start = 1'b1;
        tick();
        start = 1'b0;
        recv("mid.w0", 32'd50, 8'd0, 8'd0, 1'b0, gap);
        recv("mid.w1", 32'd60, 8'd0, 8'd1, 1'b0, gap);
        reset = 1'b1;
        tick();
        chk("mid.ctl", {11'd0, out_valid, busy, mem_rd, finished, out_last,
                        mem_addr}, 32'd0);
        chk("mid.data", out_data, 32'd0);
        chk("mid.idx", {16'd0, out_row, out_col}, 32'd0);
        reset = 1'b0;
        cnt   = 0;
        for (int k = 0; k < 10; k++) begin
            if (finished || busy)
                cnt++;
            tick();
        end
        chk("mid.nofin", 32'(cnt), 32'd0);
        drain("after_rst", 32'd50, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
